// File: rtl/ddr_axi_absent_responder_if.sv
// AXI4 bus bundle for the absent-channel responder. Every field is flattened
// across channels; channel c occupies slice c of each vector.
interface ddr_axi_absent_responder_if #(
    parameter int NUM_CH = 3,
    parameter int ID_W   = 16,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
);
    logic [NUM_CH*ID_W-1:0]       awid;
    logic [NUM_CH*ADDR_W-1:0]     awaddr;
    logic [NUM_CH*8-1:0]          awlen;
    logic [NUM_CH*2-1:0]          awburst;
    logic [NUM_CH-1:0]            awvalid;
    logic [NUM_CH-1:0]            awready;
    logic [NUM_CH*ID_W-1:0]       wid;
    logic [NUM_CH*DATA_W-1:0]     wdata;
    logic [NUM_CH*(DATA_W/8)-1:0] wstrb;
    logic [NUM_CH-1:0]            wlast;
    logic [NUM_CH-1:0]            wvalid;
    logic [NUM_CH-1:0]            wready;
    logic [NUM_CH*ID_W-1:0]       bid;
    logic [NUM_CH*2-1:0]          bresp;
    logic [NUM_CH-1:0]            bvalid;
    logic [NUM_CH-1:0]            bready;
    logic [NUM_CH*ID_W-1:0]       arid;
    logic [NUM_CH*ADDR_W-1:0]     araddr;
    logic [NUM_CH*8-1:0]          arlen;
    logic [NUM_CH*2-1:0]          arburst;
    logic [NUM_CH-1:0]            arvalid;
    logic [NUM_CH-1:0]            arready;
    logic [NUM_CH*ID_W-1:0]       rid;
    logic [NUM_CH*DATA_W-1:0]     rdata;
    logic [NUM_CH*2-1:0]          rresp;
    logic [NUM_CH-1:0]            rlast;
    logic [NUM_CH-1:0]            rvalid;
    logic [NUM_CH-1:0]            rready;

    modport master (
        output awid, awaddr, awlen, awburst, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awburst, awvalid, output awready,
        input wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/ddr_axi_absent_responder.sv
// AXI4 terminator for DDR channels without a controller. Every access is
// accepted and answered with an error response so stray traffic never hangs.

// One channel: independent write and read FSMs, access counter, error flag.
module ddr_axi_absent_ch #(
    parameter int         ID_W  = 16,
    parameter int         CNT_W = 16,
    parameter logic [1:0] RESP  = 2'b11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ID_W-1:0]  awid,
    input  logic [7:0]       awlen,
    input  logic             awvalid,
    output logic             awready,
    input  logic             wlast,
    input  logic             wvalid,
    output logic             wready,
    output logic [ID_W-1:0]  bid,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready,
    input  logic [ID_W-1:0]  arid,
    input  logic [7:0]       arlen,
    input  logic             arvalid,
    output logic             arready,
    output logic [ID_W-1:0]  rid,
    output logic [1:0]       rresp,
    output logic             rlast,
    output logic             rvalid,
    input  logic             rready,
    input  logic             err_clr,
    output logic             is_ready,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             proto_err
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t w_state, w_nxt;
    r_state_t r_state, r_nxt;

    // Write beat counter saturates so an overlong burst can never alias awlen+1.
    logic [8:0]       wbeat_q, wbeat_d;
    logic [7:0]       awlen_q, awlen_d;
    logic [7:0]       rbeat_q, rbeat_d;
    logic [7:0]       arlen_q, arlen_d;
    logic [ID_W-1:0]  bid_d, rid_d;
    logic [1:0]       bresp_d, rresp_d;
    logic             awready_d, wready_d, bvalid_d, arready_d, rvalid_d, rlast_d;
    logic             proto_err_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_sum;
    logic [1:0]       cnt_inc;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid  & wready;
    assign b_hs  = bvalid  & bready;
    assign ar_hs = arvalid & arready;
    assign r_hs  = rvalid  & rready;

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            r_state   <= R_IDLE;
            wbeat_q   <= '0;
            awlen_q   <= '0;
            rbeat_q   <= '0;
            arlen_q   <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= '0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rid       <= '0;
            rresp     <= '0;
            rlast     <= 1'b0;
            is_ready  <= 1'b0;
            acc_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            w_state   <= w_nxt;
            r_state   <= r_nxt;
            wbeat_q   <= wbeat_d;
            awlen_q   <= awlen_d;
            rbeat_q   <= rbeat_d;
            arlen_q   <= arlen_d;
            awready   <= awready_d;
            wready    <= wready_d;
            bvalid    <= bvalid_d;
            bid       <= bid_d;
            bresp     <= bresp_d;
            arready   <= arready_d;
            rvalid    <= rvalid_d;
            rid       <= rid_d;
            rresp     <= rresp_d;
            rlast     <= rlast_d;
            is_ready  <= 1'b1;
            acc_cnt   <= cnt_d;
            proto_err <= proto_err_d;
        end
    end

    // Next-state logic for both FSMs.
    always_comb begin
        w_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)         w_nxt = W_DATA;
            W_DATA:  if (w_hs && wlast) w_nxt = W_RESP;
            W_RESP:  if (b_hs)          w_nxt = W_IDLE;
            default:                    w_nxt = W_IDLE;
        endcase
        r_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)         r_nxt = R_DATA;
            R_DATA:  if (r_hs && rlast) r_nxt = R_IDLE;
            default:                    r_nxt = R_IDLE;
        endcase
    end

    // Next values of every registered output, decoded from the next state.
    always_comb begin
        awlen_d = aw_hs ? awlen : awlen_q;
        bid_d   = aw_hs ? awid  : bid;
        wbeat_d = wbeat_q;
        if (aw_hs)
            wbeat_d = '0;
        else if (w_hs && wbeat_q != 9'h1FF)
            wbeat_d = wbeat_q + 9'd1;

        arlen_d = ar_hs ? arlen : arlen_q;
        rid_d   = ar_hs ? arid  : rid;
        rbeat_d = rbeat_q;
        if (ar_hs)
            rbeat_d = '0;
        else if (r_hs)
            rbeat_d = rbeat_q + 8'd1;

        awready_d = (w_nxt == W_IDLE);
        wready_d  = (w_nxt == W_DATA);
        bvalid_d  = (w_nxt == W_RESP);
        bresp_d   = bvalid_d ? RESP : 2'b00;
        arready_d = (r_nxt == R_IDLE);
        rvalid_d  = (r_nxt == R_DATA);
        rresp_d   = rvalid_d ? RESP : 2'b00;
        rlast_d   = rvalid_d && (rbeat_d == arlen_d);

        // wbeat_q counts beats before the last one, so a match means awlen+1 beats.
        proto_err_d = (w_hs && wlast && (wbeat_q != {1'b0, awlen_q})) ||
                      (proto_err && !err_clr);

        cnt_inc = {1'b0, aw_hs} + {1'b0, ar_hs};
        cnt_sum = {1'b0, acc_cnt} + {{(CNT_W-1){1'b0}}, cnt_inc};
        cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
endmodule

// Top: one independent responder per channel over the flattened AXI bus.
module ddr_axi_absent_responder #(
    parameter int         NUM_CH = 3,
    parameter int         ID_W   = 16,
    parameter int         ADDR_W = 64,
    parameter int         DATA_W = 512,
    parameter logic [1:0] RESP   = 2'b11,
    parameter int         CNT_W  = 16
) (
    input  logic                    clk_main_a0,
    input  logic                    rst_main_n_sync,
    ddr_axi_absent_responder_if.slave bus,
    input  logic [NUM_CH-1:0]       err_clr,
    output logic [NUM_CH-1:0]       is_ready,
    output logic [NUM_CH*CNT_W-1:0] acc_cnt,
    output logic [NUM_CH-1:0]       proto_err
);
    // Read data is always zero; address, burst type, write id/data/strobe are don't-care.
    assign bus.rdata = '0;
    logic unused_inputs;
    assign unused_inputs = ^{bus.awaddr, bus.awburst, bus.wid, bus.wdata,
                             bus.wstrb, bus.araddr, bus.arburst};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ddr_axi_absent_ch #(.ID_W(ID_W), .CNT_W(CNT_W), .RESP(RESP)) u_ch (
            .clk       (clk_main_a0),
            .rst_n     (rst_main_n_sync),
            .awid      (bus.awid[c*ID_W +: ID_W]),
            .awlen     (bus.awlen[c*8 +: 8]),
            .awvalid   (bus.awvalid[c]),
            .awready   (bus.awready[c]),
            .wlast     (bus.wlast[c]),
            .wvalid    (bus.wvalid[c]),
            .wready    (bus.wready[c]),
            .bid       (bus.bid[c*ID_W +: ID_W]),
            .bresp     (bus.bresp[c*2 +: 2]),
            .bvalid    (bus.bvalid[c]),
            .bready    (bus.bready[c]),
            .arid      (bus.arid[c*ID_W +: ID_W]),
            .arlen     (bus.arlen[c*8 +: 8]),
            .arvalid   (bus.arvalid[c]),
            .arready   (bus.arready[c]),
            .rid       (bus.rid[c*ID_W +: ID_W]),
            .rresp     (bus.rresp[c*2 +: 2]),
            .rlast     (bus.rlast[c]),
            .rvalid    (bus.rvalid[c]),
            .rready    (bus.rready[c]),
            .err_clr   (err_clr[c]),
            .is_ready  (is_ready[c]),
            .acc_cnt   (acc_cnt[c*CNT_W +: CNT_W]),
            .proto_err (proto_err[c])
        );
    end
endmodule

// File: doc/ddr_axi_absent_responder.md
Name: ddr_axi_absent_responder

Overview:
- Parametrised AXI4 slave terminator for DDR channels built without a controller (channel not present).
- Sits between CL AXI masters and the absent channel slots of the shell DDR wrapper.
- Replaces static zero tie-offs with protocol-correct error responses, so a stray CL access completes with an error instead of hanging.
- Per channel, it also provides a ready flag, a saturating access counter and a sticky protocol-error flag.

Parameters:
- NUM_CH, 3: number of independent channels; each has its own write FSM and read FSM.
- ID_W, 16: AXI ID width.
- ADDR_W, 64: AXI address width. Addresses are ignored.
- DATA_W, 512: AXI data width. Write strobe width is DATA_W/8.
- RESP, 2'b11: response code on every B and R beat (2'b11 DECERR, 2'b10 SLVERR).
- CNT_W, 16: width of each per-channel access counter.

Ports:
- clk_main_a0  in  1  clock for all logic.
- rst_main_n_sync  in  1  reset; synchronous, active-low.
- awid/awaddr/awlen/awburst/awvalid  in  NUM_CH*(ID_W/ADDR_W/8/2/1)  AW channel, flattened; channel c occupies slice c.
- awready  out  NUM_CH  AW accept.
- wid/wdata/wstrb/wlast/wvalid  in  NUM_CH*(ID_W/DATA_W/DATA_W/8/1/1)  W channel. wid and wdata are ignored.
- wready  out  NUM_CH  W accept.
- bid/bresp/bvalid  out  NUM_CH*(ID_W/2/1)  B channel.
- bready  in  NUM_CH  B accept.
- arid/araddr/arlen/arburst/arvalid  in  NUM_CH*(ID_W/ADDR_W/8/2/1)  AR channel.
- arready  out  NUM_CH  AR accept.
- rid/rdata/rresp/rlast/rvalid  out  NUM_CH*(ID_W/DATA_W/2/1/1)  R channel.
- rready  in  NUM_CH  R accept.
- is_ready  out  NUM_CH  channel ready for traffic.
- acc_cnt  out  NUM_CH*CNT_W  saturating count of accepted AW plus AR.
- proto_err  out  NUM_CH  sticky flag: write beat count did not match awlen+1.
- err_clr  in  NUM_CH  clears the matching proto_err bit.

Behaviour:
- Reset (rst_main_n_sync=0 at a clk edge) drives every output to 0: all ready/valid signals, bid, bresp, rid, rdata, rresp, rlast, is_ready, acc_cnt, proto_err. Both FSMs go to IDLE.
- is_ready rises on the first edge after reset deasserts and stays high.
- All outputs are registered. Channels are fully independent; writes and reads within a channel are independent.
- A handshake occurs when valid and ready are both high at a clk edge.
- Write FSM, per channel:
  - W_IDLE: awready=1, wready=0. On AW handshake, capture awid and awlen, set beat count to 0, go to W_DATA.
  - W_DATA: awready=0, wready=1. Each W handshake increments the beat count. A handshake with wlast=1 goes to W_RESP.
  - At the wlast beat, proto_err is set if (beats including last) != awlen+1.
  - W_RESP: wready=0, bvalid=1, bid=captured id, bresp=RESP. On B handshake, return to W_IDLE.
  - wvalid before AW is not accepted (wready=0 in W_IDLE).
  - Latency: AW handshake at edge t gives wready=1 from cycle t+1. wlast handshake at edge t gives bvalid=1 from t+1.
- Read FSM, per channel:
  - R_IDLE: arready=1. On AR handshake, capture arid and arlen, set beat count to 0, go to R_DATA.
  - R_DATA: arready=0, rvalid=1, rid=captured id, rdata=0, rresp=RESP, rlast=(beat count==arlen). Each R handshake increments the beat count. A handshake with rlast=1 returns to R_IDLE with rvalid=0 on the next cycle.
  - rvalid is first asserted the cycle after the AR handshake.
  - R outputs hold stable while rvalid=1 and rready=0.
  - arlen=0 gives a single beat with rlast=1. arlen=255 gives 256 beats.
- awburst, arburst, awaddr and araddr are ignored; every burst type is answered identically.
- acc_cnt:
  - +1 per AW handshake and +1 per AR handshake.
  - Both in the same cycle give +2.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- proto_err:
  - Set has priority over err_clr in the same cycle.
  - Reset mid-burst abandons the transaction with no B or R beat issued.
- Outputs of channel c never depend on inputs of any other channel.

Test Plan:
- Reset, then idle: is_ready goes 0 to 1 one cycle after rst_main_n_sync=1; awready=arready=1; bvalid=rvalid=0; acc_cnt=0.
- Ch0 write, awid=0x12, awlen=3, 4 W beats with wlast on the 4th -> single B with bid=0x12, bresp=2'b11, proto_err[0]=0, acc_cnt[0]=1.
- Ch1 read, arid=0x5, arlen=7, rready toggled 1/0 -> 8 R beats, rdata=0, rresp=2'b11, rlast only on the 8th beat, outputs stable while stalled.
- Ch2 write with awlen=3 but wlast on beat 2 -> B returned, proto_err[2]=1. err_clr[2] pulse then gives 0. Set and clear in the same cycle leaves 1.
- Simultaneous AW and AR on ch0 with CNT_W=4, preloaded to 14 -> acc_cnt=15, then stays 15 after more accesses.
- Reset asserted mid read burst (beat 3 of 8) -> rvalid=0 and the FSM in IDLE on the next cycle; a new AR is accepted normally after reset.
